fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core. Owns the program counter and issues one-at-a-time requests to instruction memory. Buffers the returned word with its PC and presents it downstream with a valid/ready handshake; the ready/valid pair directly drives the load enable of the IF/ID pipeline register. Handles control-flow redirects from the execute stage, including redirects that arrive while a memory request is still outstanding.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  one-cycle pulse: fetch request at imem_addr
- imem_addr  out  XLEN  current fetch PC, word-aligned
- imem_rvalid  in  1  response valid; only legal ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1
- if_valid  out  1  buffered instruction available
- if_pc  out  XLEN  PC of buffered instruction
- if_instr  out  32  buffered instruction
- if_ready  in  1  downstream accepts (IF/ID load = if_valid & if_ready)
- redir_valid  in  1  control-flow redirect, one-cycle pulse
- redir_pc  in  XLEN  redirect target; bits [1:0] ignored

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DISCARD: request outstanding, its response must be dropped.
- IDLE → WAIT: imem_req=1 when (!buf_valid | if_ready) and !redir_valid.
- WAIT, imem_rvalid=1 → IDLE. The buffer captures if_pc←pc and if_instr←imem_rdata, and sets buf_valid. pc←pc+4, wrapping modulo 2^XLEN.
- WAIT, redir_valid=1, imem_rvalid=0 → DISCARD.
- WAIT, redir_valid and imem_rvalid in the same cycle → IDLE. The response is dropped.
- DISCARD, imem_rvalid=1 → IDLE. The response is dropped and pc is unchanged.
- Redirect in any state:
  - pc←{redir_pc[XLEN-1:2],2'b00}.
  - buf_valid←0.
  - Redirect takes priority over capture and over if_ready. A word presented in the redirect cycle is not considered consumed.
  - A redirect in DISCARD only updates pc.
- Consumption: if_valid & if_ready clears buf_valid unless a new capture occurs in the same cycle.
- At most one request outstanding; no prefetch.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=RESET_PC, if_instr=32'h0000_0013 (NOP).
  - State IDLE.
- First imem_req fires in the first clock edge cycle after rst deasserts.
- imem_addr equals the pc register and is stable from request until response.
- Latency: with a 1-cycle memory, req in cycle n gives if_valid=1 in cycle n+2.
- Peak throughput: one instruction per 2 cycles, reached when if_ready is held high.
- if_valid, if_pc and if_instr are registered outputs. They hold stable while if_valid=1 and if_ready=0.
- Asserting rst mid-request: return to reset values immediately. Any later imem_rvalid for the pre-reset request is the memory's responsibility to suppress.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetch_cnt [31:0], counting responses captured into the buffer.
  - Adds outputs perf_flush_cnt [31:0], counting dropped responses plus valid buffers cleared by a redirect.
  - Both counters wrap and reset to 0.
- FETCH_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package riscv_pkg holds:
  - XLEN default
  - NOP encoding (32'h0000_0013)
  - fetch FSM state enum {IDLE, WAIT, DISCARD}
  - PC increment constant 4
- Sub-module fetch_out_buf: single-entry holding register (valid, pc, instr) with capture, consume and flush inputs and asynchronous active-low reset.

## Test plan
- Reset release, memory latency 1, if_ready=1 → requests at addresses 0x0, 0x4, 0x8 every 2 cycles; if_pc follows 0x0, 0x4, 0x8 with matching if_instr.
- if_ready=0 for 5 cycles after the first capture → no new imem_req; if_pc=0x0 and if_instr stay stable; the next request (0x4) is issued in the cycle if_ready rises.
- Redirect to 0x100 while WAIT (memory latency 3) → the pending response is dropped with if_valid staying 0; the next request address is 0x100.
- redir_valid and imem_rvalid in the same cycle, redir_pc=0x203 → word dropped; the next imem_addr is 0x200.
- pc=32'hFFFF_FFFC fetched → the next request address wraps to 0x0.
- rst asserted while WAIT with if_valid=1 → outputs return to reset values asynchronously; refetch starts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RISC-V core front end.
//   XLEN_DEF  - default address/PC width
//   NOP_INSTR - canonical NOP encoding (addi x0, x0, 0)
//   PC_INC    - sequential PC increment
//   fetch_state_e - fetch FSM states
package riscv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [1:0] {
    IDLE,     // no request outstanding
    WAIT,     // request outstanding, response will be captured
    DISCARD   // request outstanding, response will be dropped
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: single-entry holding register for a fetched instruction.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   capture               - load cap_pc/cap_instr and set valid
//   consume               - downstream took the entry; clears valid
//   flush                 - clear valid; wins over capture and consume
//   cap_pc, cap_instr     - entry to load
//   valid, pc, instr      - registered entry contents
module fetch_out_buf
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            consume,
  input  logic            flush,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [31:0]     cap_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      // A capture in the same cycle as a consume replaces the entry.
      valid_d = 1'b1;
      pc_d    = cap_pc;
      instr_d = cap_instr;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one request at a
// time to instruction memory, buffers the returned word with its PC and
// presents it downstream with a valid/ready handshake. Redirects from execute
// may arrive while a request is outstanding; that response is then dropped.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   imem_req/imem_addr       - request pulse and word-aligned fetch PC
//   imem_rvalid/imem_rdata   - memory response
//   if_valid/if_pc/if_instr  - buffered instruction (registered)
//   if_ready                 - downstream accept
//   redir_valid/redir_pc     - control-flow redirect (bits [1:0] ignored)
// Optional: define FETCH_PERF_EN to add perf_fetch_cnt (captured responses)
// and perf_flush_cnt (dropped responses + valid buffers flushed by redirect).
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            if_ready,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_tgt;
  logic            req;
  logic            capture;
  logic            drop;
  logic            consume;

  assign redir_tgt = {redir_pc[XLEN-1:2], 2'b00};
  assign consume   = if_valid & if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    capture = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redir_valid && (!if_valid || if_ready)) begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          if (redir_valid) begin
            drop = 1'b1;
          end else begin
            capture = 1'b1;
            pc_d    = pc_q + XLEN'(PC_INC);
          end
        end else if (redir_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          drop    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redir_valid) begin
      pc_d = redir_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // The request is decoded from IDLE state; gating with rst keeps it low
  // while reset is held, so the first pulse follows reset release.
  assign imem_req  = req & rst;
  assign imem_addr = pc_q;

  fetch_out_buf #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst),
    .capture   (capture),
    .consume   (consume),
    .flush     (redir_valid),
    .cap_pc    (pc_q),
    .cap_instr (imem_rdata),
    .valid     (if_valid),
    .pc        (if_pc),
    .instr     (if_instr)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(capture);
    flush_cnt_d = flush_cnt_q + 32'(drop) + 32'(redir_valid & if_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. An environment memory
// answers each request after a fixed or random latency with a word derived
// from the address; a transaction-level model tracks the expected PC,
// buffered instruction and outstanding/doomed request.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        redir_valid;
  logic [31:0] redir_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_ready    (if_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [31:0] m_pc, m_bpc, m_bi;
  bit          m_bv, m_out, m_doomed;
  // environment memory
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_fix;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_0013;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pc = 32'h0; m_bpc = 32'h0; m_bi = 32'h13;
    m_bv = 0; m_out = 0; m_doomed = 0;
    mem_cnt = 0; mem_addr = 32'h0;
  endtask

  task automatic check_reset_vals();
    chk1 ("rst_imem_req",  imem_req,  1'b0);
    chk32("rst_imem_addr", imem_addr, 32'h0);
    chk1 ("rst_if_valid",  if_valid,  1'b0);
    chk32("rst_if_pc",     if_pc,     32'h0);
    chk32("rst_if_instr",  if_instr,  32'h0000_0013);
  endtask

  // Assert reset now (asynchronously), check outputs, release mid-high phase.
  task automatic do_reset();
    rst = 1'b0;
    imem_rvalid = 1'b0;
    if_ready = 1'b0;
    redir_valid = 1'b0;
    redir_pc = 32'h0;
    model_clear();
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // One cycle: drive inputs at negedge, compare against the model, advance
  // the model and the memory. Returns before the next rising edge.
  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit exp_req;
    @(negedge clk);
    if (mem_cnt > 0) begin
      mem_cnt--;
      imem_rvalid = (mem_cnt == 0);
    end else begin
      imem_rvalid = 1'b0;
    end
    imem_rdata  = imem_rvalid ? word_at(mem_addr) : $urandom;
    if_ready    = rdy;
    redir_valid = rd;
    redir_pc    = rpc;
    #1;
    exp_req = !m_out && (!m_bv || rdy) && !rd;
    chk1 ("imem_req",  imem_req,  exp_req);
    chk32("imem_addr", imem_addr, m_pc);
    chk1 ("if_valid",  if_valid,  m_bv);
    if (m_bv) begin
      chk32("if_pc",    if_pc,    m_bpc);
      chk32("if_instr", if_instr, m_bi);
    end
    if (imem_req) begin
      mem_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
      mem_addr = imem_addr;
    end
    if (rd) begin
      if (m_out && imem_rvalid) begin
        m_out = 0; m_doomed = 0;
      end else if (m_out) begin
        m_doomed = 1;
      end
      m_pc = {rpc[31:2], 2'b00};
      m_bv = 0;
    end else begin
      if (m_out && imem_rvalid) begin
        m_out = 0;
        if (m_doomed) begin
          m_doomed = 0;
        end else begin
          m_bv = 1; m_bpc = m_pc; m_bi = word_at(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end else if (m_bv && rdy) begin
        m_bv = 0;
      end
      if (exp_req) m_out = 1;
    end
  endtask

  initial begin
    rst = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    if_ready = 1'b0;
    redir_valid = 1'b0;
    redir_pc = 32'h0;
    lat_fix = 1;

    // rdy, req, addr, vld, pc -- latency-1 memory, stall 5 cycles after first capture
    tbl[0]  = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h4, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h4, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h4, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h4, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h4, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    tbl[10] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8};
    tbl[12] = '{1'b1, 1'b0, 32'hC, 1'b0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    model_clear();
    check_reset_vals();
    #1;
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0);
      chk1 ("tbl_req",  imem_req,  tbl[i].req);
      chk32("tbl_addr", imem_addr, tbl[i].addr);
      chk1 ("tbl_vld",  if_valid,  tbl[i].vld);
      if (tbl[i].vld) begin
        chk32("tbl_pc",    if_pc,    tbl[i].pc);
        chk32("tbl_instr", if_instr, word_at(tbl[i].pc));
      end
    end

    // redirect while WAIT, latency 3: response dropped, refetch at 0x100
    do_reset();
    lat_fix = 3;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk1("disc_vld", if_valid, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    chk1 ("disc_req",  imem_req,  1'b1);
    chk32("disc_addr", imem_addr, 32'h100);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    chk1 ("disc_cap_vld", if_valid, 1'b1);
    chk32("disc_cap_pc",  if_pc,    32'h100);

    // redirect and response in the same cycle, latency 2
    do_reset();
    lat_fix = 2;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b0, 32'h0);
    chk1 ("same_req",  imem_req,  1'b1);
    chk32("same_addr", imem_addr, 32'h200);
    chk1 ("same_vld",  if_valid,  1'b0);

    // PC wrap from 0xFFFF_FFFC, then reset while a request is outstanding
    do_reset();
    lat_fix = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 32'h0);
    chk32("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    lat_fix = 3;
    step(1'b1, 1'b0, 32'h0);
    chk32("wrap_pc",   if_pc,     32'hFFFF_FFFC);
    chk1 ("wrap_req",  imem_req,  1'b1);
    chk32("wrap_addr", imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    #2;
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk1 ("refetch_req",  imem_req,  1'b1);
    chk32("refetch_addr", imem_addr, 32'h0);

    // randomized traffic against the model
    lat_fix = 0;
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
